// File: rtl/ask_pkg.sv
// Shared types and width helpers for the ASK frame receiver.
package ask_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  function automatic int unsigned energy_width(input int unsigned iq_w);
    return 2 * iq_w;
  endfunction

endpackage

// File: rtl/iq_energy.sv
// Registered I^2+Q^2 energy stage with a one-deep valid pipe.
module iq_energy
  import ask_pkg::*;
#(
  parameter int unsigned IQ_W = 8,
  localparam int unsigned E_W = energy_width(IQ_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IQ_W-1:0] idata,
  input  logic signed [IQ_W-1:0] qdata,
  output logic        [E_W-1:0]  energy,
  output logic                   v1
);

  logic signed [E_W-1:0] i_ext, q_ext, i_sq, q_sq;
  logic        [E_W-1:0] energy_d, energy_q;
  logic                  v1_q;

  assign i_ext = E_W'(idata);
  assign q_ext = E_W'(qdata);
  assign i_sq  = i_ext * i_ext;
  assign q_sq  = q_ext * q_ext;
  // Sum is taken unsigned: (-MIN)^2 * 2 only fits when the MSB is magnitude.
  assign energy_d = $unsigned(i_sq) + $unsigned(q_sq);

  always_ff @(posedge clk) begin
    if (rst) begin
      energy_q <= '0;
      v1_q     <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) energy_q <= energy_d;
    end
  end

  assign energy = energy_q;
  assign v1     = v1_q;

endmodule

// File: rtl/ask_frame_rcv.sv
// ASK receiver: energy slicer with hysteresis feeding a UART-style frame deserialiser.
module ask_frame_rcv
  import ask_pkg::*;
#(
  parameter int unsigned IQ_W      = 8,
  parameter int unsigned SPS       = 16,
  parameter int unsigned DATA_BITS = 8,
  localparam int unsigned E_W      = energy_width(IQ_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IQ_W-1:0] idata,
  input  logic signed [IQ_W-1:0] qdata,
  input  logic [E_W-1:0]         thresh_hi,
  input  logic [E_W-1:0]         thresh_lo,
  output logic [E_W-1:0]         energy,
  output logic                   line_bit,
  output logic [DATA_BITS-1:0]   data,
  output logic                   data_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int unsigned CntW  = $clog2(SPS);
  localparam int unsigned BcntW = $clog2(DATA_BITS + 1);

  logic                 v1, v2_q;
  logic                 line_d, line_q, prev_q;
  state_e               state_d, state_q;
  logic [CntW-1:0]      cnt_d, cnt_q;
  logic [BcntW-1:0]     bcnt_d, bcnt_q;
  logic [DATA_BITS-1:0] sr_d, sr_q, data_d, data_q;
  logic                 dv_d, dv_q, fe_d, fe_q;

  iq_energy #(
    .IQ_W(IQ_W)
  ) u_iq_energy (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .idata   (idata),
    .qdata   (qdata),
    .energy  (energy),
    .v1      (v1)
  );

  // Set compare wins over clear, so lo > hi still gives a defined slicer.
  always_comb begin
    line_d = line_q;
    if (energy >= thresh_hi)     line_d = 1'b1;
    else if (energy < thresh_lo) line_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= 1'b1;
      prev_q <= 1'b1;
      v2_q   <= 1'b0;
    end else begin
      v2_q <= v1;
      if (v1) begin
        prev_q <= line_q;
        line_q <= line_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    if (v2_q) begin
      unique case (state_q)
        IDLE: begin
          // Falling edge only: a line stuck low never retriggers.
          if (prev_q && !line_q) begin
            state_d = START;
            cnt_d   = CntW'(1);
          end
        end
        START: begin
          if (cnt_q == CntW'(SPS / 2)) begin
            cnt_d = '0;
            if (line_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              bcnt_d  = '0;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CntW'(SPS - 1)) begin
            cnt_d                = '0;
            sr_d                 = sr_q >> 1;
            sr_d[DATA_BITS-1]    = line_q;
            if (bcnt_q == BcntW'(DATA_BITS - 1)) state_d = STOP;
            else                                 bcnt_d  = bcnt_q + BcntW'(1);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CntW'(SPS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (line_q) begin
              data_d = sr_q;
              dv_d   = 1'b1;
            end else begin
              fe_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  assign line_bit   = line_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ask_frame_rcv.sv
// Scoreboard bench for ask_frame_rcv: driver pushes expectations, negedge monitor checks them.
module tb_ask_frame_rcv;

  localparam int SPS = 16;
  localparam int DB  = 8;
  localparam int HI  = 4000;
  localparam int LO  = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [7:0] idata, qdata;
  logic [15:0]       thresh_hi, thresh_lo, energy;
  logic              line_bit, data_valid, frame_err, busy;
  logic [7:0]        data;

  ask_frame_rcv #(
    .IQ_W(8),
    .SPS(SPS),
    .DATA_BITS(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .idata     (idata),
    .qdata     (qdata),
    .thresh_hi (thresh_hi),
    .thresh_lo (thresh_lo),
    .energy    (energy),
    .line_bit  (line_bit),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {int cyc; int val;} chk_t;
  typedef struct {int cyc; int err; int data;} frm_t;
  chk_t eq[$];
  chk_t lq[$];
  chk_t bq[$];
  frm_t fq[$];

  int model_line = 1;
  int last_good  = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each expectation on the cycle it falls due.
  always @(negedge clk) begin
    if (eq.size() != 0 && eq[0].cyc <= cyc) begin
      check("energy", (eq[0].cyc == cyc) ? int'(energy) : -1, eq[0].val);
      void'(eq.pop_front());
    end
    if (lq.size() != 0 && lq[0].cyc <= cyc) begin
      check("line_bit", (lq[0].cyc == cyc) ? int'(line_bit) : -1, lq[0].val);
      void'(lq.pop_front());
    end
    if (bq.size() != 0 && bq[0].cyc <= cyc) begin
      check("busy", (bq[0].cyc == cyc) ? int'(busy) : -1, bq[0].val);
      void'(bq.pop_front());
    end
    if (data_valid || frame_err) begin
      if (fq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: data_valid=%0d frame_err=%0d data=%0h, required no pulse",
                 data_valid, frame_err, data);
      end else begin
        frm_t f;
        f = fq.pop_front();
        check("pulse_exclusive", int'(data_valid & frame_err), 0);
        check("pulse_cycle", cyc, f.cyc);
        check("pulse_is_err", int'(frame_err), f.err);
        check("pulse_data", int'(data), f.data);
      end
    end else if (fq.size() != 0 && fq[0].cyc < cyc) begin
      check("missing_pulse_at_cycle", -1, fq[0].cyc);
      void'(fq.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_sample(input int i, input int q, input int gap);
    int e;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    idata    = 8'(i);
    qdata    = 8'(q);
    in_valid = 1'b1;
    e = i * i + q * q;
    if (e >= HI)     model_line = 1;
    else if (e < LO) model_line = 0;
    eq.push_back('{cyc + 1, e});
    lq.push_back('{cyc + 2, model_line});
  endtask

  task automatic send_level(input int bitv, input int gap);
    if (bitv != 0) send_sample(100, 0, gap);
    else           send_sample(0, 0, gap);
  endtask

  // Full frame: preamble of 1s, start, LSB-first data, stop, one trailing 1 symbol.
  // mid puts a ~3000-energy sample at each symbol boundary; max_samp truncates the frame.
  task automatic send_frame(input int byte_v, input int stop_b, input int pre, input bit mid,
                            input bit gaps, input int max_samp);
    int syms[11];
    int det, k, n, pl, gap;
    syms[0] = 0;
    for (int b = 0; b < DB; b++) syms[1+b] = (byte_v >> b) & 1;
    syms[9]  = stop_b;
    syms[10] = 1;
    repeat (pre) send_level(1, gaps ? $urandom_range(1, 5) : 0);
    det = 0;
    k   = 0;
    n   = 0;
    for (int s = 0; s < 11; s++) begin
      for (int j = 0; j < SPS; j++) begin
        if (max_samp >= 0 && n >= max_samp) return;
        gap = gaps ? $urandom_range(1, 5) : 0;
        pl  = model_line;
        if (mid && j == 0) send_sample(54, 9, gap);
        else               send_level(syms[s], gap);
        n++;
        if (det != 0) begin
          k++;
          if (k == SPS * (DB + 1) + SPS / 2) begin
            if (stop_b != 0) begin
              fq.push_back('{cyc + 3, 0, byte_v});
              last_good = byte_v;
            end else begin
              fq.push_back('{cyc + 3, 1, last_good});
            end
          end
        end else if (pl == 1 && model_line == 0) begin
          det = 1;
        end
      end
    end
  endtask

  task automatic reset_dut();
    idle(4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    model_line = 1;
    last_good  = 0;
    check("rst_energy", int'(energy), 0);
    check("rst_line_bit", int'(line_bit), 1);
    check("rst_data", int'(data), 0);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    idata     = '0;
    qdata     = '0;
    thresh_hi = 16'(HI);
    thresh_lo = 16'(LO);
    reset_dut();

    // Clean frame, back-to-back samples.
    send_frame(8'hA5, 1, 32, 1'b0, 1'b0, -1);
    idle(4);

    // Short low glitch: START aborts on its mid-start sample.
    repeat (32) send_level(1, 0);
    k = 0;
    for (int s = 0; s < 24; s++) begin
      send_level(s < 4 ? 0 : 1, 0);
      if (k == 8) begin
        bq.push_back('{cyc + 2, 1});
        bq.push_back('{cyc + 3, 0});
      end
      k++;
    end
    idle(4);

    // Stop bit low: frame error, data keeps 0xA5.
    send_frame(8'h3C, 0, 32, 1'b0, 1'b0, -1);
    idle(4);

    // In-band boundary samples plus random gaps.
    send_frame(8'h81, 1, 32, 1'b1, 1'b1, -1);
    idle(4);

    // Energy extremes.
    send_sample(-128, -128, 0);
    send_sample(-1, 1, 0);
    repeat (24) send_level(1, 0);
    idle(4);

    // Randomised frames.
    for (int r = 0; r < 6; r++) begin
      send_frame(int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(16, 40)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), -1);
      idle(3);
    end

    // Random I/Q burst checks energy and slicer; too short to complete a frame.
    for (int r = 0; r < 40; r++)
      send_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 2)));
    reset_dut();

    // Reset in the middle of DATA, then a normal frame.
    send_frame(8'h5A, 1, 32, 1'b0, 1'b0, 60);
    idle(4);
    check("busy_mid_data", int'(busy), 1);
    reset_dut();
    send_frame(8'h5A, 1, 32, 1'b0, 1'b0, -1);
    idle(10);
    check("frames_pending", fq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
